// File: rtl/legv8_control_unit_if.sv
// Control-word bundle between the LEGv8 controller and the datapath core.
interface legv8_ctrl_if;
  logic [31:0] IR_out;
  logic [3:0]  status;
  logic        w_reg;
  logic        C0;
  logic        mem_cs;
  logic        mem_write_en;
  logic        IR_load;
  logic        status_load;
  logic        PC_sel;
  logic        B_Sel;
  logic [31:0] k;
  logic [4:0]  FS;
  logic [1:0]  PC_FS;
  logic [1:0]  size;
  logic [4:0]  SA;
  logic [4:0]  SB;
  logic [4:0]  DA;
  logic        add_tri_sel;
  logic [1:0]  data_tri_sel;
  logic        halted;

  modport master (
    input  IR_out, status,
    output w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, PC_sel, B_Sel,
           k, FS, PC_FS, size, SA, SB, DA, add_tri_sel, data_tri_sel, halted
  );

  modport slave (
    output IR_out, status,
    input  w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, PC_sel, B_Sel,
           k, FS, PC_FS, size, SA, SB, DA, add_tri_sel, data_tri_sel, halted
  );
endinterface

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 controller: fetch/exec/branch/halt FSM driving the datapath control word.
module legv8_control_unit #(
  parameter int unsigned MEM_WAIT = 0,
  parameter logic [4:0]  FS_AND   = 5'b00000,
  parameter logic [4:0]  FS_ORR   = 5'b00100,
  parameter logic [4:0]  FS_ADD   = 5'b01000,
  parameter logic [4:0]  FS_SUB   = 5'b01001
) (
  input  logic         clock,
  input  logic         reset,
  legv8_ctrl_if.master bus
);

  localparam int unsigned WCW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_BC   = 8'b01010100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_BRANCH, S_HALT} state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             last;

  logic [31:0] ir;
  logic [31:0] k_i12, k_d9, k_b26, k_c19;

  logic        w_reg_c, c0_c, mem_cs_c, mem_we_c, ir_load_c, status_load_c, pc_sel_c, b_sel_c;
  logic [31:0] k_c;
  logic [4:0]  fs_c, sa_c, sb_c, da_c;
  logic [1:0]  pc_fs_c, dts_c;
  logic        ats_c, halted_c;

  // Condition-code evaluation against {V,C,N,Z}; odd codes invert, except 1111 which is always.
  function automatic logic cond_met(input logic [3:0] cc, input logic [3:0] st);
    logic r;
    r = 1'b0;
    case (cc[3:1])
      3'b000: r = st[0];
      3'b001: r = st[2];
      3'b010: r = st[1];
      3'b011: r = st[3];
      3'b100: r = st[2] & ~st[0];
      3'b101: r = (st[1] == st[3]);
      3'b110: r = ~st[0] & (st[1] == st[3]);
      3'b111: r = 1'b1;
      default: r = 1'b0;
    endcase
    if (cc[0] && (cc[3:1] != 3'b111)) r = ~r;
    return r;
  endfunction

  assign ir    = bus.IR_out;
  assign last  = (wcnt_q == WCW'(MEM_WAIT));
  assign k_i12 = {20'd0, ir[21:10]};
  assign k_d9  = {{23{ir[20]}}, ir[20:12]};
  // Branch offsets subtract 4 because FETCH has already advanced the PC.
  assign k_b26 = ({{6{ir[25]}}, ir[25:0]} << 2) - 32'd4;
  assign k_c19 = ({{13{ir[23]}}, ir[23:5]} << 2) - 32'd4;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    w_reg_c       = 1'b0;
    c0_c          = 1'b0;
    mem_cs_c      = 1'b0;
    mem_we_c      = 1'b0;
    ir_load_c     = 1'b0;
    status_load_c = 1'b0;
    pc_sel_c      = 1'b0;
    b_sel_c       = 1'b0;
    k_c           = 32'd0;
    fs_c          = FS_AND;
    sa_c          = 5'd0;
    sb_c          = 5'd0;
    da_c          = 5'd0;
    pc_fs_c       = 2'b00;
    dts_c         = 2'd0;
    ats_c         = 1'b1;
    halted_c      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_cs_c = 1'b1;
        dts_c    = 2'd3;
        if (last) begin
          ir_load_c = 1'b1;
          pc_fs_c   = 2'b01;
          state_d   = S_EXEC;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end

      S_EXEC: begin
        if (ir[31:21] == OP_ADD || ir[31:21] == OP_SUB ||
            ir[31:21] == OP_AND || ir[31:21] == OP_ORR) begin
          sa_c    = ir[9:5];
          sb_c    = ir[20:16];
          da_c    = ir[4:0];
          w_reg_c = 1'b1;
          c0_c    = (ir[31:21] == OP_SUB);
          fs_c    = (ir[31:21] == OP_AND) ? FS_AND :
                    (ir[31:21] == OP_ORR) ? FS_ORR :
                    (ir[31:21] == OP_SUB) ? FS_SUB : FS_ADD;
          state_d = S_FETCH;
        end else if (ir[31:22] == OP_ADDI || ir[31:22] == OP_SUBI) begin
          sa_c    = ir[9:5];
          da_c    = ir[4:0];
          b_sel_c = 1'b1;
          k_c     = k_i12;
          w_reg_c = 1'b1;
          c0_c    = (ir[31:22] == OP_SUBI);
          fs_c    = (ir[31:22] == OP_SUBI) ? FS_SUB : FS_ADD;
          state_d = S_FETCH;
        end else if (ir[31:21] == OP_LDUR || ir[31:21] == OP_STUR) begin
          sa_c     = ir[9:5];
          b_sel_c  = 1'b1;
          k_c      = k_d9;
          fs_c     = FS_ADD;
          ats_c    = 1'b0;
          mem_cs_c = 1'b1;
          if (ir[31:21] == OP_LDUR) begin
            dts_c   = 2'd3;
            da_c    = ir[4:0];
            w_reg_c = last;
          end else begin
            dts_c    = 2'd1;
            sb_c     = ir[4:0];
            mem_we_c = last;
          end
          if (last) state_d = S_FETCH;
          else      wcnt_d  = wcnt_q + WCW'(1);
        end else if (ir[31:26] == OP_B) begin
          pc_sel_c = 1'b1;
          pc_fs_c  = 2'b10;
          k_c      = k_b26;
          state_d  = S_FETCH;
        end else if (ir[31:24] == OP_BC) begin
          if (cond_met(ir[3:0], bus.status)) begin
            pc_fs_c = 2'b10;
            k_c     = k_c19;
          end
          state_d = S_FETCH;
        end else if (ir[31:24] == OP_CBZ || ir[31:24] == OP_CBNZ) begin
          // Test Rt through the ALU; this overwrites the flags.
          sa_c          = ir[4:0];
          b_sel_c       = 1'b1;
          fs_c          = FS_ADD;
          status_load_c = 1'b1;
          state_d       = S_BRANCH;
        end else begin
          state_d = S_HALT;
        end
      end

      S_BRANCH: begin
        if (bus.status[0] ^ ir[24]) begin
          pc_fs_c = 2'b10;
          k_c     = k_c19;
        end
        state_d = S_FETCH;
      end

      S_HALT: halted_c = 1'b1;

      default: state_d = S_HALT;
    endcase

    if (state_d != state_q) wcnt_d = '0;
  end

  // Every output is forced low while reset is held, including mid-access.
  assign bus.w_reg        = reset & w_reg_c;
  assign bus.C0           = reset & c0_c;
  assign bus.mem_cs       = reset & mem_cs_c;
  assign bus.mem_write_en = reset & mem_we_c;
  assign bus.IR_load      = reset & ir_load_c;
  assign bus.status_load  = reset & status_load_c;
  assign bus.PC_sel       = reset & pc_sel_c;
  assign bus.B_Sel        = reset & b_sel_c;
  assign bus.k            = reset ? k_c     : 32'd0;
  assign bus.FS           = reset ? fs_c    : 5'd0;
  assign bus.PC_FS        = reset ? pc_fs_c : 2'd0;
  assign bus.size         = reset ? 2'b11   : 2'd0;
  assign bus.SA           = reset ? sa_c    : 5'd0;
  assign bus.SB           = reset ? sb_c    : 5'd0;
  assign bus.DA           = reset ? da_c    : 5'd0;
  assign bus.add_tri_sel  = reset & ats_c;
  assign bus.data_tri_sel = reset ? dts_c   : 2'd0;
  assign bus.halted       = reset & halted_c;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed bench for the LEGv8 controller: MEM_WAIT=0 and MEM_WAIT=2 instances, scoreboard checks.
module tb_legv8_control_unit;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  legv8_ctrl_if b0 ();
  legv8_ctrl_if b1 ();

  legv8_control_unit #(.MEM_WAIT(0)) dut0 (.clock(clk), .reset(rst0), .bus(b0));
  legv8_control_unit #(.MEM_WAIT(2)) dut1 (.clock(clk), .reset(rst1), .bus(b1));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] I_ADDI = 32'h91001441;  // ADDI X1,X2,#5
  localparam logic [31:0] I_SUB  = 32'hCB020023;  // SUB X3,X1,X2
  localparam logic [31:0] I_BEQ  = 32'h54000060;  // B.EQ imm19=3
  localparam logic [31:0] I_B    = 32'h14000005;  // B imm26=5
  localparam logic [31:0] I_CBNZ = 32'hB5000045;  // CBNZ X5 imm19=2
  localparam logic [31:0] I_LDUR = 32'hF85F8083;  // LDUR X3,[X4,#-8]
  localparam logic [31:0] I_STUR = 32'hF81F8083;  // STUR X3,[X4,#-8]

  task automatic e(input string tag, input logic [31:0] v);
    exp_t x;
    x.tag = tag;
    x.val = v;
    sb.push_back(x);
  endtask

  task automatic c(input logic [31:0] obs);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.val)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.val);
      end
    end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    b0.IR_out = 32'd0; b0.status = 4'd0;
    b1.IR_out = 32'd0; b1.status = 4'd0;

    // Reset held: every output low
    repeat (3) @(negedge clk);
    e("rst_mem_cs", 0); e("rst_add_tri", 0); e("rst_size", 0); e("rst_ir_load", 0);
    c(32'(b0.mem_cs)); c(32'(b0.add_tri_sel)); c(32'(b0.size)); c(32'(b0.IR_load));

    rst0 = 1'b1; b0.IR_out = I_ADDI; #1;
    e("f_mem_cs", 1); e("f_ir_load", 1); e("f_pc_fs", 1); e("f_dts", 3);
    c(32'(b0.mem_cs)); c(32'(b0.IR_load)); c(32'(b0.PC_FS)); c(32'(b0.data_tri_sel));

    @(negedge clk);
    e("addi_sa", 2); e("addi_da", 1); e("addi_bsel", 1); e("addi_k", 5);
    e("addi_fs", 8); e("addi_wreg", 1); e("addi_c0", 0);
    c(32'(b0.SA)); c(32'(b0.DA)); c(32'(b0.B_Sel)); c(b0.k);
    c(32'(b0.FS)); c(32'(b0.w_reg)); c(32'(b0.C0));

    @(negedge clk);
    e("addi_back_fetch", 1); c(32'(b0.IR_load));
    b0.IR_out = I_SUB;

    @(negedge clk);
    e("sub_fs", 9); e("sub_c0", 1); e("sub_sa", 1); e("sub_sb", 2);
    e("sub_da", 3); e("sub_bsel", 0); e("sub_wreg", 1);
    c(32'(b0.FS)); c(32'(b0.C0)); c(32'(b0.SA)); c(32'(b0.SB));
    c(32'(b0.DA)); c(32'(b0.B_Sel)); c(32'(b0.w_reg));

    @(negedge clk);
    b0.IR_out = I_BEQ; b0.status = 4'b0001;
    @(negedge clk);
    e("beq_taken_pcfs", 2); e("beq_taken_k", 8);
    c(32'(b0.PC_FS)); c(b0.k);

    @(negedge clk);
    b0.status = 4'b0000;
    @(negedge clk);
    e("beq_not_taken_pcfs", 0); c(32'(b0.PC_FS));

    @(negedge clk);
    e("beq_back_fetch", 1); c(32'(b0.mem_cs));
    b0.IR_out = I_B;
    @(negedge clk);
    e("b_pcsel", 1); e("b_pcfs", 2); e("b_k", 16);
    c(32'(b0.PC_sel)); c(32'(b0.PC_FS)); c(b0.k);

    // CBNZ with nonzero register: flags Z=0 in BRANCH
    @(negedge clk);
    b0.IR_out = I_CBNZ; b0.status = 4'b0000;
    @(negedge clk);
    e("cbnz_sl", 1); e("cbnz_sa", 5); e("cbnz_k", 0); e("cbnz_fs", 8); e("cbnz_pcfs", 0);
    c(32'(b0.status_load)); c(32'(b0.SA)); c(b0.k); c(32'(b0.FS)); c(32'(b0.PC_FS));
    @(negedge clk);
    e("cbnz_taken_pcfs", 2); e("cbnz_taken_k", 4); e("cbnz_br_sl", 0);
    c(32'(b0.PC_FS)); c(b0.k); c(32'(b0.status_load));

    // CBNZ with zero register: Z=1, not taken
    @(negedge clk);
    e("cbnz_back_fetch", 1); c(32'(b0.mem_cs));
    b0.status = 4'b0001;
    @(negedge clk);
    e("cbnz2_sl", 1); c(32'(b0.status_load));
    @(negedge clk);
    e("cbnz_not_taken_pcfs", 0); c(32'(b0.PC_FS));

    @(negedge clk);
    b0.IR_out = 32'd0;
    @(negedge clk);
    e("bad_exec_wreg", 0); e("bad_exec_halted", 0);
    c(32'(b0.w_reg)); c(32'(b0.halted));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e("halt_halted", 1); e("halt_mem_cs", 0); e("halt_wreg", 0); e("halt_ir_load", 0); e("halt_mwe", 0);
      c(32'(b0.halted)); c(32'(b0.mem_cs)); c(32'(b0.w_reg)); c(32'(b0.IR_load)); c(32'(b0.mem_write_en));
    end
    rst0 = 1'b0; #1;
    e("halt_rst_halted", 0); c(32'(b0.halted));
    @(negedge clk);
    rst0 = 1'b1; #1;
    e("halt_exit_mem_cs", 1); e("halt_exit_halted", 0); e("halt_exit_ir_load", 1);
    c(32'(b0.mem_cs)); c(32'(b0.halted)); c(32'(b0.IR_load));

    // MEM_WAIT=2 instance: 3-cycle fetch, LDUR, STUR, reset during STUR
    @(negedge clk);
    rst1 = 1'b1; b1.IR_out = I_LDUR; #1;
    e("w_f0_mem_cs", 1); e("w_f0_ir_load", 0);
    c(32'(b1.mem_cs)); c(32'(b1.IR_load));
    @(negedge clk);
    e("w_f1_ir_load", 0); c(32'(b1.IR_load));
    @(negedge clk);
    e("w_f2_ir_load", 1); e("w_f2_pcfs", 1);
    c(32'(b1.IR_load)); c(32'(b1.PC_FS));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e("ldur_mem_cs", 1); e("ldur_ats", 0); e("ldur_k", 32'hFFFFFFF8);
      e("ldur_dts", 3); e("ldur_sa", 4); e("ldur_da", 3); e("ldur_wreg", (i == 2) ? 1 : 0);
      c(32'(b1.mem_cs)); c(32'(b1.add_tri_sel)); c(b1.k);
      c(32'(b1.data_tri_sel)); c(32'(b1.SA)); c(32'(b1.DA)); c(32'(b1.w_reg));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e("w_fetch_ir_load", (i == 2) ? 1 : 0); c(32'(b1.IR_load));
    end
    b1.IR_out = I_STUR;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e("stur_mwe", (i == 2) ? 1 : 0); e("stur_dts", 1); e("stur_sb", 3);
      e("stur_mem_cs", 1); e("stur_wreg", 0); e("stur_ats", 0);
      c(32'(b1.mem_write_en)); c(32'(b1.data_tri_sel)); c(32'(b1.SB));
      c(32'(b1.mem_cs)); c(32'(b1.w_reg)); c(32'(b1.add_tri_sel));
    end
    repeat (3) @(negedge clk);
    @(negedge clk);
    e("stur2_c0_mwe", 0); e("stur2_c0_mem_cs", 1);
    c(32'(b1.mem_write_en)); c(32'(b1.mem_cs));
    @(negedge clk);
    e("stur2_c1_mwe", 0); c(32'(b1.mem_write_en));
    rst1 = 1'b0; #1;
    e("stur_rst_mem_cs", 0); e("stur_rst_mwe", 0); e("stur_rst_dts", 0);
    c(32'(b1.mem_cs)); c(32'(b1.mem_write_en)); c(32'(b1.data_tri_sel));
    repeat (2) begin
      @(negedge clk);
      e("stur_rst_hold_mwe", 0); c(32'(b1.mem_write_en));
    end
    rst1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e("post_rst_mwe", 0); e("post_rst_mem_cs", 1);
      c(32'(b1.mem_write_en)); c(32'(b1.mem_cs));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
